// File: rtl/dmp_control_unit_if.sv
// Control/status bundle between the DMP sequencing FSM and its SUM/N datapath.
// master = controller side, slave = datapath side.
interface dmp_control_unit_if;
    logic       start;
    logic       n_zero;
    logic       ld_n;
    logic       clr_sum;
    logic       acc_en;
    logic       dec_en;
    logic       busy;
    logic       done;
    logic       led;
    logic [7:0] iter_cnt;

    modport master (
        input  start, n_zero,
        output ld_n, clr_sum, acc_en, dec_en, busy, done, led, iter_cnt
    );

    modport slave (
        output start, n_zero,
        input  ld_n, clr_sum, acc_en, dec_en, busy, done, led, iter_cnt
    );
endinterface

// File: rtl/dmp_control_unit.sv
// Sequencer that sums N + (N-1) + ... + 1 on an external datapath (Moore strobes).
// Optional macro DMP_LED_BLINK_EN: blink the LED in DONE with a half-period of BLINK_DIV cycles.
module dmp_control_unit #(
    parameter int BLINK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    dmp_control_unit_if.master ctrl
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TEST,
        S_ACC,
        S_DEC,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_iterCnt;
    logic       w_led;

    if (BLINK_DIV < 1 || BLINK_DIV > 255) begin : g_badBlinkDiv
        $error("BLINK_DIV must be in 1..255");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state depends on inputs; every strobe is decoded from r_state alone.
    always_comb begin
        w_nextState  = r_state;
        ctrl.ld_n    = 1'b0;
        ctrl.clr_sum = 1'b0;
        ctrl.acc_en  = 1'b0;
        ctrl.dec_en  = 1'b0;
        ctrl.busy    = 1'b0;
        ctrl.done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ctrl.start) begin
                    w_nextState = S_LOAD;
                end
            end
            S_LOAD: begin
                ctrl.ld_n    = 1'b1;
                ctrl.clr_sum = 1'b1;
                ctrl.busy    = 1'b1;
                w_nextState  = S_TEST;
            end
            S_TEST: begin
                ctrl.busy   = 1'b1;
                w_nextState = ctrl.n_zero ? S_DONE : S_ACC;
            end
            S_ACC: begin
                ctrl.acc_en = 1'b1;
                ctrl.busy   = 1'b1;
                w_nextState = S_DEC;
            end
            S_DEC: begin
                ctrl.dec_en = 1'b1;
                ctrl.busy   = 1'b1;
                w_nextState = S_TEST;
            end
            S_DONE: begin
                ctrl.done = 1'b1;
                if (ctrl.start) begin
                    w_nextState = S_LOAD;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Cleared as LOAD is entered so the count already reads 0 during LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iterCnt <= 8'd0;
        end else if (w_nextState == S_LOAD) begin
            r_iterCnt <= 8'd0;
        end else if (r_state == S_ACC && r_iterCnt != 8'hFF) begin
            r_iterCnt <= r_iterCnt + 8'd1;
        end
    end

    assign ctrl.iter_cnt = r_iterCnt;

`ifdef DMP_LED_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);

    logic [7:0] r_blinkCnt;
    logic       r_ledPhase;

    // Held preset outside DONE, so every DONE entry starts lit with a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blinkCnt <= 8'd0;
            r_ledPhase <= 1'b0;
        end else if (r_state != S_DONE) begin
            r_blinkCnt <= 8'd0;
            r_ledPhase <= 1'b1;
        end else if (r_blinkCnt == BLINK_LAST) begin
            r_blinkCnt <= 8'd0;
            r_ledPhase <= ~r_ledPhase;
        end else begin
            r_blinkCnt <= r_blinkCnt + 8'd1;
        end
    end

    assign w_led = (r_state == S_DONE) && r_ledPhase;
`else
    assign w_led = (r_state == S_DONE);
`endif

    assign ctrl.led = w_led;

endmodule

// File: tb/tb_dmp_control_unit.sv
// Bench for dmp_control_unit: datapath model, cycle-level reference model, directed runs.
// Honours DMP_LED_BLINK_EN the same way as the design.
module tb_dmp_control_unit;

    localparam int BLINK_DIV = 4;

    logic       clk;
    logic       rst;
    logic [7:0] nBus;
    logic [7:0] nReg;
    logic [15:0] sumReg;
    int         checks = 0;
    int         errors = 0;
    int         accCount = 0;

    dmp_control_unit_if bus ();

    dmp_control_unit #(.BLINK_DIV(BLINK_DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus.master)
    );

    always #5 clk = ~clk;

    // Datapath the controller drives: N register, SUM accumulator, zero flag.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            nReg   <= 8'd0;
            sumReg <= 16'd0;
        end else begin
            if (bus.ld_n)        nReg <= nBus;
            else if (bus.dec_en) nReg <= nReg - 8'd1;
            if (bus.clr_sum)     sumReg <= 16'd0;
            else if (bus.acc_en) sumReg <= sumReg + 16'(nReg);
        end
    end

    assign bus.n_zero = (nReg == 8'd0);

    always @(posedge clk) begin
        if (bus.acc_en === 1'b1) accCount <= accCount + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a run is described only by its N and the cycles elapsed since start was taken.
    int mActive;
    int mK;
    int mN;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mActive <= 0;
            mK      <= 0;
            mN      <= 0;
        end else if ((mActive == 0 || mK >= 3 * mN + 2) && bus.start === 1'b1) begin
            mActive <= 1;
            mK      <= 0;
            mN      <= int'(nBus);
        end else if (mActive != 0) begin
            mK <= mK + 1;
        end
    end

    always @(negedge clk) begin
        logic expLd, expAcc, expDec, expBusy, expDone, expLed;
        int   expIter;
        int   d;
        int   r;
        expLd = 0; expAcc = 0; expDec = 0; expBusy = 0; expDone = 0; expLed = 0;
        expIter = 0; d = 0; r = 0;
        if (mActive != 0) begin
            if (mK == 0) begin
                expLd   = 1;
                expBusy = 1;
            end else if (mK >= 3 * mN + 2) begin
                expDone = 1;
                expIter = mN;
                d       = mK - (3 * mN + 2);
`ifdef DMP_LED_BLINK_EN
                expLed  = ((d / BLINK_DIV) % 2) == 0;
`else
                expLed  = 1;
`endif
            end else begin
                expBusy = 1;
                expIter = mK / 3;
                r       = (mK - 1) % 3;
                expAcc  = (r == 1);
                expDec  = (r == 2);
            end
        end
        checkOutput("ld_n",     32'(bus.ld_n),     32'(expLd));
        checkOutput("clr_sum",  32'(bus.clr_sum),  32'(expLd));
        checkOutput("acc_en",   32'(bus.acc_en),   32'(expAcc));
        checkOutput("dec_en",   32'(bus.dec_en),   32'(expDec));
        checkOutput("busy",     32'(bus.busy),     32'(expBusy));
        checkOutput("done",     32'(bus.done),     32'(expDone));
        checkOutput("led",      32'(bus.led),      32'(expLed));
        checkOutput("iter_cnt", 32'(bus.iter_cnt), 32'(expIter));
    end

    // Called just after a rising edge; returns edges from the start-sampling edge to done.
    task automatic applyStimulus(input int n, input bit noisy, output int edges);
        nBus      = 8'(n);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("run_start_ld_n", 32'(bus.ld_n), 32'd1);
        checkOutput("run_start_led",  32'(bus.led),  32'd0);
        checkOutput("run_start_busy", 32'(bus.busy), 32'd1);
        edges = 0;
        while (edges < 2000) begin
            @(posedge clk);
            edges++;
            #1;
            bus.start = noisy && edges < 700 && (edges % 37 == 5);
            if (bus.done === 1'b1) break;
        end
        bus.start = 1'b0;
        if (bus.done !== 1'b1) checkOutput("run_timeout_done", 32'(bus.done), 32'd1);
    endtask

    initial begin
        int edges;
        int accBefore;
        logic [7:0] ledPat;
        int waitCnt;

`ifdef DMP_LED_BLINK_EN
        ledPat = 8'b0000_1111;
`else
        ledPat = 8'b1111_1111;
`endif
        clk = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0;
        nBus = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(bus.busy),     32'd0);
        checkOutput("reset_done", 32'(bus.done),     32'd0);
        checkOutput("reset_led",  32'(bus.led),      32'd0);
        checkOutput("reset_iter", 32'(bus.iter_cnt), 32'd0);
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("idle_hold_busy", 32'(bus.busy), 32'd0);

        $display("[TB] run N=0");
        accBefore = accCount;
        applyStimulus(0, 1'b0, edges);
        checkOutput("n0_edges", 32'(edges),           32'd2);
        checkOutput("n0_iter",  32'(bus.iter_cnt),    32'd0);
        checkOutput("n0_acc",   32'(accCount - accBefore), 32'd0);

        $display("[TB] led pattern in DONE");
        for (int i = 0; i < 8; i++) begin
            checkOutput("led_done", 32'(bus.led), 32'(ledPat[i]));
            @(posedge clk);
            #1;
        end

        $display("[TB] run N=2 restarted from DONE");
        applyStimulus(2, 1'b0, edges);
        checkOutput("n2_edges", 32'(edges),        32'd8);
        checkOutput("n2_iter",  32'(bus.iter_cnt), 32'd2);
        checkOutput("n2_sum",   32'(sumReg),       32'd3);

        $display("[TB] run N=255 with stray start pulses");
        applyStimulus(255, 1'b1, edges);
        checkOutput("n255_edges", 32'(edges),        32'd767);
        checkOutput("n255_iter",  32'(bus.iter_cnt), 32'd255);
        checkOutput("n255_sum",   32'(sumReg),       32'd32640);

        $display("[TB] reset during ACC");
        nBus = 8'd85;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitCnt = 0;
        while (bus.acc_en !== 1'b1 && waitCnt < 20) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        checkOutput("mid_acc_seen", 32'(bus.acc_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_ld_n",    32'(bus.ld_n),     32'd0);
        checkOutput("mid_rst_clr_sum", 32'(bus.clr_sum),  32'd0);
        checkOutput("mid_rst_acc_en",  32'(bus.acc_en),   32'd0);
        checkOutput("mid_rst_dec_en",  32'(bus.dec_en),   32'd0);
        checkOutput("mid_rst_busy",    32'(bus.busy),     32'd0);
        checkOutput("mid_rst_done",    32'(bus.done),     32'd0);
        checkOutput("mid_rst_led",     32'(bus.led),      32'd0);
        checkOutput("mid_rst_iter",    32'(bus.iter_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        $display("[TB] run N=15 after reset");
        applyStimulus(15, 1'b0, edges);
        checkOutput("n15_edges", 32'(edges),        32'd47);
        checkOutput("n15_iter",  32'(bus.iter_cnt), 32'd15);
        checkOutput("n15_sum",   32'(sumReg),       32'd120);

        repeat (3) begin @(posedge clk); #1; end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
